// File: rtl/sdram_refresh_sched.sv
// SDRAM auto-refresh scheduler.
// An interval timer earns refresh credits (debt). A request goes to the
// arbiter while debt is outstanding. Each grant runs an optional
// PRECHARGE-ALL followed by a burst of up to REF_BURST AUTO-REFRESH commands,
// with tRP and tRFC spacing.
//
// Arbiter handshake: ref_rq is a level request that stays high while the
// scheduler is idle with debt outstanding. ref_en is a one-cycle grant. It is
// accepted only when the scheduler is idle and debt is non-zero, and it is
// ignored at all other times. ref_rq drops the cycle after the grant is
// accepted. ref_end pulses for one cycle when the sequence has finished.
module sdram_refresh_sched #(
  parameter int ADDR_WIDTH   = 12,
  parameter int REF_INTERVAL = 750,
  parameter int REF_BURST    = 1,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int MAX_DEBT     = 8,
  parameter int PRECHARGE_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_end,
  input  logic                  ref_en,
  output logic                  ref_rq,
  output logic                  ref_urgent,
  output logic                  ref_busy,
  output logic                  ref_end,
  output logic                  ref_err,
  output logic [3:0]            debt,
  output logic [3:0]            sdram_cmd,
  output logic [ADDR_WIDTH-1:0] ref_addr
);

  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  localparam int TW = $clog2(REF_INTERVAL + 1);
  localparam int WW = $clog2(T_RP + T_RFC + 1);

  localparam logic [TW-1:0] CNT_LAST = TW'(REF_INTERVAL - 1);
  // Last wait-counter value of each NOP gap. A gap of length 0 skips its
  // state entirely, so the clamp only keeps the constant legal.
  localparam logic [WW-1:0] RP_LAST  = WW'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [WW-1:0] RFC_LAST = WW'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [3:0]    DEBT_MAX = 4'(MAX_DEBT);
  localparam logic [3:0]    DEBT_URG = 4'(MAX_DEBT - 1);
  localparam logic [3:0]    BURST_N  = 4'(REF_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_AREF,
    S_WAIT_RFC,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]    debt_q, debt_d;
  logic [3:0]    burst_q, burst_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          rq_q, rq_d;
  logic          busy_q, busy_d;
  logic          end_q, end_d;
  logic          err_q, err_d;

  logic tick;
  logic grant;
  logic aref_issue;
  logic more;

  // Interval timer: runs only while init_end is high and wraps on the tick.
  always_comb begin
    tick = init_end && (cnt_q == CNT_LAST);
    if (!init_end || tick) cnt_d = '0;
    else                   cnt_d = cnt_q + TW'(1);
  end

  // Credit bookkeeping: earn on the tick, spend on each AREF, saturate at MAX_DEBT.
  always_comb begin
    grant      = (state_q == S_IDLE) && ref_en && (debt_q != 4'd0);
    aref_issue = (state_q == S_AREF);
    debt_d     = debt_q;
    err_d      = err_q;
    if (tick && !aref_issue) begin
      if (debt_q >= DEBT_MAX) err_d  = 1'b1;
      else                    debt_d = debt_q + 4'd1;
    end else if (aref_issue && !tick) begin
      debt_d = debt_q - 4'd1;
    end
  end

  // Sequencer next state. The burst continues only while the post-update
  // debt is non-zero, so an AREF is never issued without a credit.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q + {3'b000, aref_issue};
    more    = (burst_d < BURST_N) && (debt_d != 4'd0);
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = (PRECHARGE_EN != 0) ? S_PRE : S_AREF;
      end
      S_PRE: begin
        wait_d = '0;
        if (T_RP > 1) state_d = S_WAIT_RP;
        else          state_d = S_AREF;
      end
      S_WAIT_RP: begin
        if (wait_q == RP_LAST) state_d = S_AREF;
        else                   wait_d  = wait_q + WW'(1);
      end
      S_AREF: begin
        wait_d = '0;
        if (T_RFC > 1) state_d = S_WAIT_RFC;
        else           state_d = more ? S_AREF : S_DONE;
      end
      S_WAIT_RFC: begin
        if (wait_q == RFC_LAST) state_d = more ? S_AREF : S_DONE;
        else                    wait_d  = wait_q + WW'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
        burst_d = 4'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs, decoded from the next state so that they line up with it.
  always_comb begin
    case (state_d)
      S_PRE:   cmd_d = CMD_PRE;
      S_AREF:  cmd_d = CMD_AREF;
      default: cmd_d = CMD_NOP;
    endcase
    busy_d = (state_d != S_IDLE);
    end_d  = (state_d == S_DONE);
    rq_d   = (state_q == S_IDLE) && (debt_q != 4'd0) && !grant;
  end

  // All state and outputs update here; reset aborts any running sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      debt_q  <= 4'd0;
      burst_q <= 4'd0;
      wait_q  <= '0;
      cmd_q   <= CMD_NOP;
      rq_q    <= 1'b0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      debt_q  <= debt_d;
      burst_q <= burst_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
      rq_q    <= rq_d;
      busy_q  <= busy_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  assign ref_rq     = rq_q;
  assign ref_urgent = (debt_q >= DEBT_URG);
  assign ref_busy   = busy_q;
  assign ref_end    = end_q;
  assign ref_err    = err_q;
  assign debt       = debt_q;
  assign sdram_cmd  = cmd_q;
  assign ref_addr   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << 10;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Bench for sdram_refresh_sched. Instance 0 uses the default timing with a
// burst of 4. Instance 1 has no precharge, single-cycle tRFC, a short interval
// and a small MAX_DEBT. A queue-based reference model predicts every output of
// both instances on every cycle, and directed checks cover the test plan.
module tb_sdram_refresh_sched;

  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  // instance 0 / instance 1 parameters
  localparam int I0_INT = 750, I0_BURST = 4, I0_RP = 2, I0_RFC = 7, I0_MAX = 8, I0_PE = 1;
  localparam int I1_INT = 40,  I1_BURST = 2, I1_RP = 1, I1_RFC = 1, I1_MAX = 3, I1_PE = 0;

  function automatic int p_int(int i);   return (i == 0) ? I0_INT   : I1_INT;   endfunction
  function automatic int p_burst(int i); return (i == 0) ? I0_BURST : I1_BURST; endfunction
  function automatic int p_rp(int i);    return (i == 0) ? I0_RP    : I1_RP;    endfunction
  function automatic int p_rfc(int i);   return (i == 0) ? I0_RFC   : I1_RFC;   endfunction
  function automatic int p_max(int i);   return (i == 0) ? I0_MAX   : I1_MAX;   endfunction
  function automatic int p_pe(int i);    return (i == 0) ? I0_PE    : I1_PE;    endfunction

  // clock / reset and DUT wiring
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, init0, en0, rq0, urg0, busy0, end0, err0;
  logic [3:0] debt0, cmd0;
  logic [11:0] addr0;
  logic rst1_n, init1, en1, rq1, urg1, busy1, end1, err1;
  logic [3:0] debt1, cmd1;
  logic [12:0] addr1;

  sdram_refresh_sched #(
    .ADDR_WIDTH(12), .REF_INTERVAL(I0_INT), .REF_BURST(I0_BURST), .T_RP(I0_RP),
    .T_RFC(I0_RFC), .MAX_DEBT(I0_MAX), .PRECHARGE_EN(I0_PE)
  ) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .init_end(init0), .ref_en(en0), .ref_rq(rq0),
    .ref_urgent(urg0), .ref_busy(busy0), .ref_end(end0), .ref_err(err0),
    .debt(debt0), .sdram_cmd(cmd0), .ref_addr(addr0)
  );

  sdram_refresh_sched #(
    .ADDR_WIDTH(13), .REF_INTERVAL(I1_INT), .REF_BURST(I1_BURST), .T_RP(I1_RP),
    .T_RFC(I1_RFC), .MAX_DEBT(I1_MAX), .PRECHARGE_EN(I1_PE)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .init_end(init1), .ref_en(en1), .ref_rq(rq1),
    .ref_urgent(urg1), .ref_busy(busy1), .ref_end(end1), .ref_err(err1),
    .debt(debt1), .sdram_cmd(cmd1), .ref_addr(addr1)
  );

  // scoreboard counters
  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. A grant expands into a queue of expected bus slots,
  // each slot being {decide, done, cmd}. When the last slot of a tRFC gap
  // retires, the burst rule decides whether another AREF group or the DONE
  // slot follows.
  logic [5:0] m_seq [2][64];
  int         m_rd [2];
  int         m_len [2];
  logic [5:0] m_cur [2];
  logic       m_busy [2];
  int         m_tcnt [2];
  int         m_debt [2];
  int         m_burst [2];
  logic       m_err [2];
  logic       m_rq [2];

  task automatic push(int i, logic [5:0] e);
    m_seq[i][m_len[i]] = e;
    m_len[i]++;
  endtask

  task automatic push_slot(int i);
    push(i, {(p_rfc(i) == 1), 1'b0, CMD_AREF});
    for (int k = 1; k < p_rfc(i); k++) push(i, {(k == p_rfc(i) - 1), 1'b0, CMD_NOP});
  endtask

  task automatic model_edge(int i, logic rst_n, logic init, logic en);
    logic tick, aref, grant;
    if (!rst_n) begin
      m_tcnt[i] = 0; m_debt[i] = 0; m_burst[i] = 0;
      m_err[i] = 1'b0; m_rq[i] = 1'b0; m_busy[i] = 1'b0; m_cur[i] = '0;
      return;
    end
    tick      = init && (m_tcnt[i] == p_int(i) - 1);
    m_tcnt[i] = (!init || tick) ? 0 : m_tcnt[i] + 1;
    aref      = m_busy[i] && (m_cur[i][3:0] == CMD_AREF);
    grant     = !m_busy[i] && en && (m_debt[i] != 0);
    m_rq[i]   = !m_busy[i] && (m_debt[i] != 0) && !grant;
    if (tick && !aref) begin
      if (m_debt[i] == p_max(i)) m_err[i] = 1'b1;
      else                       m_debt[i]++;
    end else if (aref && !tick) begin
      m_debt[i]--;
    end
    if (aref) m_burst[i]++;
    if (m_busy[i]) begin
      if (m_cur[i][4]) begin
        m_busy[i] = 1'b0;
        m_burst[i] = 0;
      end else begin
        if (m_cur[i][5]) begin
          if (m_burst[i] < p_burst(i) && m_debt[i] != 0) push_slot(i);
          else push(i, {1'b0, 1'b1, CMD_NOP});
        end
        m_cur[i] = m_seq[i][m_rd[i]];
        m_rd[i]++;
      end
    end else if (grant) begin
      m_rd[i] = 0;
      m_len[i] = 0;
      if (p_pe(i) != 0) begin
        push(i, {2'b00, CMD_PRE});
        for (int k = 1; k < p_rp(i); k++) push(i, {2'b00, CMD_NOP});
      end
      push_slot(i);
      m_cur[i]  = m_seq[i][0];
      m_rd[i]   = 1;
      m_busy[i] = 1'b1;
    end
  endtask

  task automatic check_outputs(int i);
    logic [3:0] o_cmd, o_debt, e_cmd;
    logic o_rq, o_urg, o_busy, o_end, o_err;
    if (i == 0) begin
      o_cmd = cmd0; o_debt = debt0; o_rq = rq0; o_urg = urg0;
      o_busy = busy0; o_end = end0; o_err = err0;
    end else begin
      o_cmd = cmd1; o_debt = debt1; o_rq = rq1; o_urg = urg1;
      o_busy = busy1; o_end = end1; o_err = err1;
    end
    e_cmd = m_busy[i] ? m_cur[i][3:0] : CMD_NOP;
    chk($sformatf("d%0d_cmd", i),    32'(o_cmd),  32'(e_cmd));
    chk($sformatf("d%0d_debt", i),   32'(o_debt), 32'(m_debt[i]));
    chk($sformatf("d%0d_rq", i),     32'(o_rq),   32'(m_rq[i]));
    chk($sformatf("d%0d_urgent", i), 32'(o_urg),  32'(m_debt[i] >= p_max(i) - 1));
    chk($sformatf("d%0d_busy", i),   32'(o_busy), 32'(m_busy[i]));
    chk($sformatf("d%0d_end", i),    32'(o_end),  32'(m_busy[i] && m_cur[i][4]));
    chk($sformatf("d%0d_err", i),    32'(o_err),  32'(m_err[i]));
  endtask

  // driver: one clock, model update, check #1 after the edge, then new random input
  logic rand1 = 1'b0;

  task automatic step();
    @(posedge clk);
    model_edge(0, rst0_n, init0, en0);
    model_edge(1, rst1_n, init1, en1);
    #1;
    check_outputs(0);
    check_outputs(1);
    en1 = rand1 ? ($urandom_range(0, 7) == 0) : 1'b0;
  endtask

  int n, cnt_a, cnt_p, cnt_b, cnt_e, last_a, urg_debt, held;
  logic seen_urg, seen_end, rq_back;

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; init0 = 1'b1; init1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
    repeat (3) step();
    chk("d0_ref_addr", 32'(addr0), 32'h400);
    chk("d1_ref_addr", 32'(addr1), 32'h400);
    rst0_n = 1'b1; rst1_n = 1'b1;
    rand1 = 1'b1;

    // first credit arrives on the REF_INTERVAL-th edge after reset release
    n = 0;
    while (debt0 == 4'd0 && n < 2000) begin step(); n++; end
    chk("t1_first_tick_cycle", 32'(n), 32'd750);
    repeat (9) step();
    en0 = 1'b1; step(); en0 = 1'b0;
    cnt_a = 0; cnt_b = 1; cnt_e = 0;
    chk("t1_first_cmd_pre", 32'(cmd0), 32'(CMD_PRE));
    repeat (20) begin
      step();
      if (busy0) cnt_b++;
      if (cmd0 == CMD_AREF) cnt_a++;
      if (end0) cnt_e++;
    end
    chk("t1_busy_cycles", 32'(cnt_b), 32'd10);
    chk("t1_aref_count", 32'(cnt_a), 32'd1);
    chk("t1_end_pulses", 32'(cnt_e), 32'd1);
    chk("t1_debt_after", 32'(debt0), 32'd0);

    // instance 1: no precharge, init_end dropped mid-burst holds the timer
    rand1 = 1'b0;
    n = 0;
    while (!(debt1 == 4'd3 && !busy1 && m_tcnt[1] == 1) && n < 1500) begin step(); n++; end
    chk("d1_fill_timeout", 32'(n < 1500), 32'd1);
    en1 = 1'b1; step(); en1 = 1'b0;
    chk("d1_first_cmd_aref", 32'(cmd1), 32'(CMD_AREF));
    step();
    init1 = 1'b0;
    repeat (5) step();
    held = int'(debt1);
    chk("d1_burst_debt", 32'(debt1), 32'd1);
    repeat (25) step();
    chk("d1_timer_held", 32'(debt1), 32'(held));
    init1 = 1'b1;
    n = 0;
    while (int'(debt1) == held && n < 100) begin step(); n++; end
    chk("d1_restart_tick_cycle", 32'(n), 32'd40);
    rand1 = 1'b1;

    // no grants: debt saturates at MAX_DEBT, urgency from MAX_DEBT-1, then overflow
    n = 0; seen_urg = 1'b0; urg_debt = 0;
    while (!err0 && n < 8000) begin
      step(); n++;
      if (urg0 && !seen_urg) begin seen_urg = 1'b1; urg_debt = int'(debt0); end
    end
    chk("t2_urgent_from_debt", 32'(urg_debt), 32'd7);
    chk("t2_err_set", 32'(err0), 32'd1);
    chk("t2_debt_saturated", 32'(debt0), 32'd8);

    // burst of 4 out of a debt of 6
    rst0_n = 1'b0; step(); rst0_n = 1'b1;
    chk("t3_err_cleared", 32'(err0), 32'd0);
    n = 0;
    while (debt0 != 4'd6 && n < 5000) begin step(); n++; end
    chk("t3_fill_timeout", 32'(n < 5000), 32'd1);
    repeat ($urandom_range(1, 50)) step();
    en0 = 1'b1; step(); en0 = 1'b0;
    cnt_a = 0; cnt_p = (cmd0 == CMD_PRE) ? 1 : 0; last_a = -1; seen_end = 1'b0; rq_back = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (cmd0 == CMD_PRE) cnt_p++;
      if (cmd0 == CMD_AREF) begin
        if (last_a >= 0) chk("t3_aref_spacing", 32'(c - last_a), 32'd7);
        last_a = c;
        cnt_a++;
      end
      if (end0) seen_end = 1'b1;
      if (seen_end && rq0) rq_back = 1'b1;
    end
    chk("t3_aref_count", 32'(cnt_a), 32'd4);
    chk("t3_pre_count", 32'(cnt_p), 32'd1);
    chk("t3_debt_after", 32'(debt0), 32'd2);
    chk("t3_rq_reasserts", 32'(rq_back), 32'd1);

    // tick landing on the AREF cycle, stray grant during WAIT_RFC
    n = 0;
    while (debt0 != 4'd3 && n < 1000) begin step(); n++; end
    n = 0;
    while (m_tcnt[0] != 746 && n < 1000) begin step(); n++; end
    chk("t5_align_timeout", 32'(n < 1000), 32'd1);
    en0 = 1'b1; step(); en0 = 1'b0;
    repeat (3) step();
    chk("t5_debt_tick_aref", 32'(debt0), 32'd3);
    repeat (2) step();
    en0 = 1'b1; step(); en0 = 1'b0;
    n = 0;
    while (busy0 && n < 60) begin step(); n++; end
    cnt_b = 0;
    repeat (30) begin step(); if (busy0) cnt_b++; end
    chk("t5_no_second_seq", 32'(cnt_b), 32'd0);
    chk("t5_debt_after", 32'(debt0), 32'd0);

    // reset inside WAIT_RFC aborts without ref_end
    n = 0;
    while (debt0 == 4'd0 && n < 1000) begin step(); n++; end
    en0 = 1'b1; step(); en0 = 1'b0;
    repeat (4) step();
    rst0_n = 1'b0; step(); rst0_n = 1'b1;
    chk("t6_cmd_nop", 32'(cmd0), 32'(CMD_NOP));
    chk("t6_debt_zero", 32'(debt0), 32'd0);
    chk("t6_busy_low", 32'(busy0), 32'd0);
    cnt_e = int'(end0);
    repeat (20) begin step(); if (end0) cnt_e++; end
    chk("t6_no_end_pulse", 32'(cnt_e), 32'd0);
    chk("d0_ref_addr_end", 32'(addr0), 32'h400);
    chk("d1_ref_addr_end", 32'(addr1), 32'h400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_refresh_sched.md
Name: sdram_refresh_sched

Overview:
Parametrised SDRAM auto-refresh scheduler, successor to the single-shot refresh block. It accumulates refresh credits from a programmable interval timer and requests the bus from the SDRAM arbiter. When granted, it issues PRECHARGE-ALL followed by a burst of up to REF_BURST AUTO-REFRESH commands, honouring tRP and tRFC. It tracks postponed refreshes as a saturating debt counter and flags urgency and overflow to the arbiter.

Parameters:
ADDR_WIDTH, 12, SDRAM address bus width; must be >= 11 (A10 used).
REF_INTERVAL, 750, clock cycles per refresh credit.
REF_BURST, 1, maximum AUTO-REFRESH commands per grant; range 1..8.
T_RP, 2, precharge-to-refresh cycles; must be >= 1.
T_RFC, 7, refresh-to-next-command cycles; must be >= 1.
MAX_DEBT, 8, saturation value of the credit counter; range 1..15.
PRECHARGE_EN, 1, 1 = issue PRECHARGE-ALL before the burst; 0 = skip the PRE/WAIT_RP states.

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  synchronous, active-low reset
init_end  in  1  SDRAM init complete; interval timer runs only while high
ref_en  in  1  grant from arbiter; 1-cycle pulse, sampled only in IDLE
ref_rq  out  1  refresh request to arbiter; registered
ref_urgent  out  1  debt >= MAX_DEBT-1
ref_busy  out  1  high in every state except IDLE
ref_end  out  1  1-cycle pulse marking sequence completion
ref_err  out  1  sticky credit-overflow flag
debt  out  4  current outstanding refresh credits
sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}: PRECHARGE 0010, AREF 0001, NOP 0111
ref_addr  out  ADDR_WIDTH  bit 10 = 1, all other bits 0; constant

Behaviour:
- Reset (synchronous, rst_n=0 at the clk edge):
  - State goes to IDLE; interval counter, debt, burst counter and wait counter clear to 0.
  - sdram_cmd=NOP; ref_rq, ref_busy, ref_end and ref_err clear to 0.
  - Reset mid-sequence aborts the sequence immediately; no ref_end pulse.
- Interval timer:
  - While init_end=0, the counter clears to 0 and holds.
  - While init_end=1, it counts 0..REF_INTERVAL-1 and wraps. The wrap cycle produces a tick.
  - init_end falling mid-sequence clears the timer only; the running sequence completes.
- Debt arithmetic (per cycle): debt_next = debt + tick - aref_issue.
  - Increment and decrement in the same cycle leave debt unchanged.
  - Saturates at MAX_DEBT. A tick at MAX_DEBT with no decrement sets ref_err; ref_err clears only on reset.
- ref_rq: registered; equals (state==IDLE && debt!=0 && !grant_this_cycle).
  - Rises one cycle after debt leaves 0.
  - Falls the cycle after ref_en is accepted.
- ref_urgent: combinational from the debt register.
- FSM states: IDLE, PRE, WAIT_RP, AREF, WAIT_RFC, DONE.
- IDLE:
  - ref_en=1 and debt!=0: go to PRE if PRECHARGE_EN, else AREF.
  - ref_en=1 with debt==0 is ignored.
  - ref_en in any other state is ignored.
- PRE: sdram_cmd=PRECHARGE for 1 cycle. Then WAIT_RP for T_RP-1 cycles of NOP (skipped if T_RP==1), then AREF.
- AREF:
  - sdram_cmd=AREF for 1 cycle; debt decrements and the burst count increments.
  - Then WAIT_RFC for T_RFC-1 cycles of NOP (skipped if T_RFC==1).
- WAIT_RFC exit:
  - If burst count < REF_BURST and debt != 0, go back to AREF (no new precharge).
  - Otherwise go to DONE.
- DONE: sdram_cmd=NOP, ref_end=1 for exactly 1 cycle; then IDLE with burst count cleared.
- Output timing: sdram_cmd is registered from the state. A grant sampled at edge k puts the first command on the bus in cycle k+1.
- Default sequence from the grant cycle:
  - Cycle 1: PRE.
  - Cycle 2: NOP.
  - Cycle 3: AREF.
  - Cycles 4-9: NOP.
  - Cycle 10: NOP with ref_end=1.
  - Total 10 cycles busy.
- Burst count is 4 bits; debt is 4 bits regardless of MAX_DEBT.

Test Plan:
1. Defaults, init_end=1 from reset, rst_n release at t0 -> first tick at cycle 750; debt=1; ref_rq=1 at 751. Grant at 760 -> PRE@761, NOP@762, AREF@763, NOP@764-769, ref_end@770; debt=0; ref_rq stays 0.
2. No grant for 8×750 cycles (MAX_DEBT=8) -> debt climbs 1..8; ref_urgent=1 from debt=7. The 9th tick sets ref_err=1 with debt held at 8.
3. REF_BURST=4, debt=6, single grant -> exactly 4 AREFs, each 7 cycles apart, with one leading PRE; debt=2 afterwards; ref_rq re-asserts after DONE.
4. REF_BURST=4, debt=1 -> one AREF only, then DONE; early exit on zero debt.
5. Tick coincides with the AREF cycle while debt=3 -> debt stays 3. ref_en pulsed during WAIT_RFC -> ignored, with no second sequence.
6. rst_n=0 during WAIT_RFC, then a 2nd run with PRECHARGE_EN=0 and init_end dropped mid-burst:
   - Reset during WAIT_RFC -> next cycle sdram_cmd=NOP, debt=0, ref_busy=0, no ref_end.
   - PRECHARGE_EN=0 -> sequence starts with AREF.
   - init_end drop mid-burst -> the burst completes and the timer holds at 0.
